mmio_console: RTL and testbench
===============================

MMIO_CONSOLE -- requirements
Module: mmio_console

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0000_1000: base of the 16-byte MMIO window, which sits just above the 4096-byte RAM.
REQ-002 Parameter CLKS_PER_BIT, default 4: clock cycles per UART bit.
REQ-003 Parameter FIFO_DEPTH, default 8: TX FIFO entries; SHALL be a power of two, at least 2.
REQ-004 clk  input  1  sole clock; all state updates on posedge.
REQ-005 rst  input  1  asynchronous, active-low reset (asserted when 0).
REQ-006 ena  input  1  global enable; when 0, all state holds and bus writes are ignored.
REQ-007 mem_addr  input  32  core memory address.
REQ-008 mem_wr_data  input  32  core write data; only bits [7:0] are used.
REQ-009 mem_wr_ena  input  1  core write strobe.
REQ-010 mem_access  input  mem_access_t  access size; accepted for any size, no exception raised.
REQ-011 hit  output  1  combinational; 1 when mem_addr[31:4] == BASE_ADDR[31:4].
REQ-012 mem_rd_data  output  32  combinational read data; 0 when hit=0.
REQ-013 uart_tx  output  1  serial line; idle high.
REQ-014 tx_busy  output  1  1 while a frame is on the line.

Function
REQ-015 Register map, offset = mem_addr[3:0]:
- 0x0 TXDATA: write pushes the byte; reads return 0.
- 0x4 STATUS: read only.
- 0x8 DROPPED: 32-bit count; any write clears it.
- 0xC: reads 0; writes ignored.
REQ-016 STATUS bits: [0] fifo_full, [1] fifo_empty, [2] tx_busy, [7:4] fifo_count (saturated at 15), all other bits 0.
REQ-017 A write takes effect at the posedge where hit=1, mem_wr_ena=1 and ena=1; reads reflect state combinationally in the same cycle.
REQ-018 A push when the FIFO is full and no pop happens that cycle SHALL be dropped and SHALL increment DROPPED, saturating at 32'hFFFF_FFFF.
REQ-019 A push and a pop in the same cycle on a full FIFO SHALL both succeed; count is unchanged.
REQ-020 A DROPPED clear and an increment in the same cycle: the clear wins.
REQ-021 Transmit FSM states: S_IDLE, S_START, S_DATA, S_STOP.
REQ-022 S_IDLE -> S_START when the FIFO is non-empty; the FIFO pops in that same cycle and the byte is latched into the shift register.
REQ-023 S_START drives 0 for CLKS_PER_BIT cycles, then -> S_DATA.
REQ-024 S_DATA drives 8 bits LSB-first, CLKS_PER_BIT cycles each, using a 3-bit index; after bit 7 -> S_STOP.
REQ-025 S_STOP drives 1 for CLKS_PER_BIT cycles, then -> S_START if the FIFO is non-empty (with pop), else -> S_IDLE.
REQ-026 Back-to-back frames have no idle gap; each frame is exactly 10*CLKS_PER_BIT cycles.
REQ-027 uart_tx is registered; the first start-bit cycle appears one cycle after the FIFO pop.
REQ-028 tx_busy=1 in S_START, S_DATA and S_STOP; 0 in S_IDLE.
REQ-029 The baud counter wraps from CLKS_PER_BIT-1 to 0; it resets to 0 on every state transition.
REQ-030 ena=0 mid-frame freezes the FSM, baud counter and uart_tx level; the frame resumes exactly where it stopped when ena returns to 1.

Reset
REQ-031 Asserting rst (0) SHALL immediately and asynchronously set: uart_tx=1, tx_busy=0, state S_IDLE, FIFO empty, DROPPED=0, baud counter and bit index 0.
REQ-032 Reset mid-frame SHALL abort the frame with no further bits sent; the first posedge after rst=1 starts from S_IDLE.

Structure
REQ-033 Package mmio_console_pkg SHALL hold: register offsets, STATUS bit positions, and the uart_state_t enum.
REQ-034 The FIFO SHALL be a sub-module, byte_fifo: parameterized depth, push/pop/full/empty/count, same clk/rst.
REQ-035 Total RTL SHALL be 120-400 lines.

Verification
REQ-036 Write 0xA5 to 0x1000 -> one cycle later uart_tx=0 for 4 cycles, then bits 1,0,1,0,0,1,0,1 (4 cycles each), then 1 for 4 cycles; tx_busy high for 40 cycles.
REQ-037 Write 0x01, 0x02, 0x03 on consecutive cycles -> three contiguous 40-cycle frames with no idle cycle between them; STATUS reads 0x02 after the third frame ends.
REQ-038 Stall the UART and write 10 bytes -> STATUS[0]=1, fifo_count=8, DROPPED reads 2; a write to 0x1008 -> DROPPED reads 0.
REQ-039 Deassert ena for 7 cycles during data bit 3 -> the bit lasts 11 cycles total and the frame completes correctly.
REQ-040 Pull rst to 0 mid-frame (asynchronously, between edges) -> uart_tx=1 and tx_busy=0 immediately, and no further frame after release.
REQ-041 Reads at 0x0FFC and 0x1010 -> hit=0, mem_rd_data=0; a write to 0x1010 leaves the FIFO unchanged.

Source files
------------

// File: rtl/mmio_console_pkg.sv
// Shared definitions for the MMIO console: register offsets, STATUS layout,
// bus access sizes and transmit FSM states.
package mmio_console_pkg;

   typedef enum logic [1:0] {ACC_BYTE, ACC_HALF, ACC_WORD} mem_access_t;

   localparam logic [3:0] OFF_TXDATA  = 4'h0;
   localparam logic [3:0] OFF_STATUS  = 4'h4;
   localparam logic [3:0] OFF_DROPPED = 4'h8;

   localparam int unsigned ST_FULL    = 0;
   localparam int unsigned ST_EMPTY   = 1;
   localparam int unsigned ST_BUSY    = 2;
   localparam int unsigned ST_CNT_LSB = 4;

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_t;

endpackage

// File: rtl/mmio_console_byte_fifo.sv
// Byte FIFO with first-word-fall-through output; a push on a full FIFO is
// accepted only when a pop happens in the same cycle.
module byte_fifo #(
   parameter int unsigned DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [7:0]               din,
   output logic [7:0]               dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int unsigned AW = $clog2(DEPTH);

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/mmio_console.sv
// Memory-mapped UART console: a 16-byte register window feeding a TX FIFO
// and an 8N1 serial transmitter with a DROPPED overflow counter.
module mmio_console
   import mmio_console_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR    = 32'h0000_1000,
   parameter int unsigned CLKS_PER_BIT = 4,
   parameter int unsigned FIFO_DEPTH   = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ena,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wr_data,
   input  logic        mem_wr_ena,
   input  mem_access_t mem_access,
   output logic        hit,
   output logic [31:0] mem_rd_data,
   output logic        uart_tx,
   output logic        tx_busy
);
   localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
   localparam int unsigned BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

   logic [3:0]    off;
   logic          wr_sel, push, clr, pop_req, pop, drop;
   logic [7:0]    fifo_dout;
   logic          fifo_full, fifo_empty;
   logic [CW-1:0] fifo_count;
   logic [31:0]   count_wide;
   logic [3:0]    cnt_sat;
   logic [7:0]    status;
   logic [31:0]   dropped;
   logic          unused_ok;

   uart_state_t   state, state_n;
   logic [BW-1:0] baud, baud_n;
   logic [2:0]    bit_idx, bit_n;
   logic [7:0]    shreg, sh_n;
   logic          tx_n, baud_last;

   assign unused_ok = ^{mem_wr_data[31:8], mem_access};

   assign off    = mem_addr[3:0];
   assign hit    = (mem_addr[31:4] == BASE_ADDR[31:4]);
   assign wr_sel = hit && mem_wr_ena && ena;
   assign push   = wr_sel && (off == OFF_TXDATA);
   assign clr    = wr_sel && (off == OFF_DROPPED);
   assign pop    = pop_req && ena;
   assign drop   = push && fifo_full && !pop;

   byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .din   (mem_wr_data[7:0]),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   assign count_wide = 32'(fifo_count);
   assign cnt_sat    = (count_wide > 32'd15) ? 4'hF : count_wide[3:0];

   always_comb begin
      status                     = '0;
      status[ST_FULL]            = fifo_full;
      status[ST_EMPTY]           = fifo_empty;
      status[ST_BUSY]            = tx_busy;
      status[ST_CNT_LSB +: 4]    = cnt_sat;
   end

   always_comb begin
      mem_rd_data = '0;
      if (hit) begin
         case (off)
            OFF_STATUS:  mem_rd_data = {24'h0, status};
            OFF_DROPPED: mem_rd_data = dropped;
            default:     mem_rd_data = '0;
         endcase
      end
   end

   // Clear has priority over a same-cycle overflow increment.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                         dropped <= '0;
      else if (clr)                     dropped <= '0;
      else if (drop && (dropped != '1)) dropped <= dropped + 1'b1;
   end

   assign tx_busy   = (state != S_IDLE);
   assign baud_last = (baud == BAUD_LAST);

   // tx_n is the line level for the cycle after this edge, keeping uart_tx registered.
   always_comb begin
      state_n = state;
      baud_n  = baud_last ? '0 : baud + 1'b1;
      bit_n   = bit_idx;
      sh_n    = shreg;
      tx_n    = uart_tx;
      pop_req = 1'b0;
      case (state)
         S_IDLE: begin
            baud_n = '0;
            tx_n   = 1'b1;
            if (!fifo_empty) begin
               pop_req = 1'b1;
               sh_n    = fifo_dout;
               state_n = S_START;
               tx_n    = 1'b0;
            end
         end
         S_START: begin
            if (baud_last) begin
               state_n = S_DATA;
               bit_n   = '0;
               tx_n    = shreg[0];
            end
         end
         S_DATA: begin
            if (baud_last) begin
               if (bit_idx == 3'd7) begin
                  state_n = S_STOP;
                  tx_n    = 1'b1;
               end else begin
                  bit_n = bit_idx + 1'b1;
                  tx_n  = shreg[bit_n];
               end
            end
         end
         S_STOP: begin
            if (baud_last) begin
               if (!fifo_empty) begin
                  pop_req = 1'b1;
                  sh_n    = fifo_dout;
                  state_n = S_START;
                  tx_n    = 1'b0;
               end else begin
                  state_n = S_IDLE;
                  tx_n    = 1'b1;
               end
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= S_IDLE;
         baud    <= '0;
         bit_idx <= '0;
         shreg   <= '0;
         uart_tx <= 1'b1;
      end else if (ena) begin
         state   <= state_n;
         baud    <= baud_n;
         bit_idx <= bit_n;
         shreg   <= sh_n;
         uart_tx <= tx_n;
      end
   end

endmodule

// File: tb/tb_mmio_console.sv
// Scoreboard bench for mmio_console: writes queue expected bytes, a serial
// monitor decodes frames off uart_tx and compares them in order.
module tb_mmio_console;
   import mmio_console_pkg::*;

   logic        clk = 1'b0;
   logic        rst, ena;
   logic [31:0] mem_addr, mem_wr_data;
   logic        mem_wr_ena;
   mem_access_t mem_access;
   logic        hit;
   logic [31:0] mem_rd_data;
   logic        uart_tx, tx_busy;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   logic [7:0] exp_q[$];
   int starts[$];

   mmio_console #(
      .BASE_ADDR   (32'h0000_1000),
      .CLKS_PER_BIT(4),
      .FIFO_DEPTH  (8)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .ena        (ena),
      .mem_addr   (mem_addr),
      .mem_wr_data(mem_wr_data),
      .mem_wr_ena (mem_wr_ena),
      .mem_access (mem_access),
      .hit        (hit),
      .mem_rd_data(mem_rd_data),
      .uart_tx    (uart_tx),
      .tx_busy    (tx_busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic void check(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h", name, got, exp);
      end
   endfunction

   // Serial monitor: collects 40 enabled-cycle samples per frame.
   initial begin : monitor
      logic [39:0] s;
      logic [7:0]  b;
      int          n;
      bit          act, ok, busy_all;
      n = 0; act = 0; busy_all = 1; s = '0;
      forever begin
         @(negedge clk);
         if (rst !== 1'b1) begin
            act = 0; n = 0;
         end else if (ena) begin
            if (!act && uart_tx === 1'b0) begin
               act = 1; n = 0; busy_all = 1;
               starts.push_back(cyc);
            end
            if (act) begin
               s[n] = uart_tx;
               busy_all = busy_all && (tx_busy === 1'b1);
               n++;
               if (n == 40) begin
                  act = 0;
                  ok = (s[3:0] == 4'h0) && (s[39:36] == 4'hF) && busy_all;
                  for (int i = 0; i < 8; i++) begin
                     b[i] = s[4+4*i];
                     if (s[4+4*i +: 4] != {4{s[4+4*i]}}) ok = 0;
                  end
                  if (exp_q.size() == 0) begin
                     total++; bad++;
                     $display("FAIL unexpected_frame: got=%h expected=none", b);
                  end else begin
                     check("frame", {23'h0, ok, b}, {23'h0, 1'b1, exp_q.pop_front()});
                  end
               end
            end
         end
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
      mem_addr = a; mem_wr_data = d; mem_wr_ena = 1'b1;
      tick();
      mem_wr_ena = 1'b0;
   endtask

   task automatic send(input logic [7:0] b, input bit accepted);
      if (accepted) exp_q.push_back(b);
      bus_write(32'h0000_1000, {24'hABCDEF, b});
   endtask

   task automatic read_check(input string name, input logic [31:0] a,
                             input logic [31:0] exp, input logic exp_hit);
      mem_addr = a; mem_wr_ena = 1'b0;
      #1;
      check({name, "_hit"}, 32'(hit), 32'(exp_hit));
      check(name, mem_rd_data, exp);
   endtask

   task automatic wait_idle(output int busy_cnt);
      bit done;
      done = 0; busy_cnt = 0;
      for (int i = 0; i < 3000 && !done; i++) begin
         if (tx_busy) busy_cnt++;
         else if (busy_cnt > 0) done = 1;
         if (!done) tick();
      end
      check("idle_timeout", 32'(done), 32'd1);
      check("drain", exp_q.size(), 0);
   endtask

   initial begin : watchdog
      #300000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      int bc, ones;
      rst = 1'b0; ena = 1'b1; mem_addr = '0; mem_wr_data = '0;
      mem_wr_ena = 1'b0; mem_access = ACC_WORD;
      tick(2);
      check("rst_tx", 32'(uart_tx), 32'd1);
      check("rst_busy", 32'(tx_busy), 32'd0);
      read_check("rst_status", 32'h0000_1004, 32'h02, 1'b1);
      read_check("rst_dropped", 32'h0000_1008, 32'h0, 1'b1);
      rst = 1'b1;
      tick(2);

      // Single frame 0xA5
      send(8'hA5, 1);
      check("a5_pre_tx", 32'(uart_tx), 32'd1);
      check("a5_pre_busy", 32'(tx_busy), 32'd0);
      tick();
      check("a5_start_tx", 32'(uart_tx), 32'd0);
      check("a5_start_busy", 32'(tx_busy), 32'd1);
      wait_idle(bc);
      check("a5_busy_len", bc, 40);
      tick(3);

      // Three back-to-back frames
      starts.delete();
      send(8'h01, 1); send(8'h02, 1); send(8'h03, 1);
      wait_idle(bc);
      check("burst_frames", starts.size(), 3);
      if (starts.size() == 3) begin
         check("gap_1_2", starts[1] - starts[0], 40);
         check("gap_2_3", starts[2] - starts[1], 40);
         check("burst_len", cyc - starts[0], 120);
      end
      read_check("burst_status", 32'h0000_1004, 32'h02, 1'b1);
      tick(3);

      // Overflow while the transmitter is mid-frame
      send(8'h11, 1);
      tick(2);
      for (int i = 0; i < 10; i++) send(8'h20 + 8'(i), i < 8);
      read_check("full_status", 32'h0000_1004, 32'h85, 1'b1);
      read_check("dropped_2", 32'h0000_1008, 32'd2, 1'b1);
      bus_write(32'h0000_1008, 32'h0);
      read_check("dropped_clr", 32'h0000_1008, 32'd0, 1'b1);
      wait_idle(bc);
      tick(3);

      // ena low for 7 cycles during data bit 3 of 0x08
      send(8'h08, 1);
      bc = 0; ones = 0;
      for (int i = 0; i < 100; i++) begin
         if (i == 18) ena = 1'b0;
         if (i == 25) ena = 1'b1;
         if (tx_busy) begin
            bc++;
            if (uart_tx) ones++;
         end
         tick();
      end
      check("stall_busy_len", bc, 47);
      check("stall_ones", ones, 15);
      check("stall_drain", exp_q.size(), 0);

      // Asynchronous reset mid-frame with a second byte queued
      send(8'h00, 1); send(8'h00, 1);
      tick(10);
      check("mid_tx", 32'(uart_tx), 32'd0);
      check("mid_busy", 32'(tx_busy), 32'd1);
      #2 rst = 1'b0;
      #1;
      check("arst_tx", 32'(uart_tx), 32'd1);
      check("arst_busy", 32'(tx_busy), 32'd0);
      exp_q.delete();
      tick(2);
      rst = 1'b1;
      bc = 0;
      for (int i = 0; i < 100; i++) begin
         if (tx_busy) bc++;
         tick();
      end
      check("post_rst_busy", bc, 0);
      read_check("post_rst_status", 32'h0000_1004, 32'h02, 1'b1);

      // Window boundaries and unused offsets
      read_check("below_window", 32'h0000_0FFC, 32'h0, 1'b0);
      read_check("above_window", 32'h0000_1010, 32'h0, 1'b0);
      read_check("off_c", 32'h0000_100C, 32'h0, 1'b1);
      read_check("txdata_read", 32'h0000_1000, 32'h0, 1'b1);
      tick();
      bus_write(32'h0000_1010, 32'h55);
      read_check("outside_wr_status", 32'h0000_1004, 32'h02, 1'b1);
      bc = 0;
      for (int i = 0; i < 60; i++) begin
         if (tx_busy) bc++;
         tick();
      end
      check("outside_wr_busy", bc, 0);

      check("final_queue", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
